// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory-access stage: data-bus handshake, wait/timeout FSM, MEM/WB register
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] ExMem_AluResult,
  input  logic [31:0] ExMem_AluB_Pc4,
  input  logic        ExMem_MemRead,
  input  logic        ExMem_MemWrite,
  input  logic        ExMem_MemToReg,
  input  logic [4:0]  ExMem_RegRd,
  input  logic        ExMem_RegWrite,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [31:0] DMem_WData,
  input  logic        DMem_Ready,
  input  logic [31:0] DMem_RData,
  output logic        Mem_Stall,
  output logic        Mem_Misalign,
  output logic        Mem_BusErr,
  output logic [4:0]  MemWb_RegRd,
  output logic        MemWb_RegWrite,
  output logic        MemWb_MemToReg,
  output logic [31:0] MemWb_AluResult,
  output logic [31:0] MemWb_ReadData,
  output logic [31:0] Wb_RegWData
);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT      state, stateNext;
  logic [7:0] cnt, cntNext;
  logic       isMem, access, misaligned, lastCycle, complete, abort, stall;

  assign isMem      = ExMem_MemRead | ExMem_MemWrite;
  assign access     = isMem & (ExMem_AluResult[1:0] == 2'b00);
  assign misaligned = isMem & (ExMem_AluResult[1:0] != 2'b00);
  assign lastCycle  = (state == WAIT) && (cnt == 8'(TIMEOUT - 1));
  assign complete   = access & DMem_Ready;
  assign abort      = access & ~DMem_Ready & lastCycle;
  assign stall      = access & ~DMem_Ready & ~lastCycle;

  // Bus-side outputs are gated by reset so an in-flight transfer vanishes immediately
  assign DMem_Req   = access & rstb;
  assign DMem_We    = ExMem_MemWrite & rstb;
  assign DMem_Addr  = rstb ? {ExMem_AluResult[31:2], 2'b00} : 32'd0;
  assign DMem_WData = rstb ? ExMem_AluB_Pc4 : 32'd0;
  assign Mem_Stall  = stall & rstb;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (access && !DMem_Ready) begin
          stateNext = WAIT;
          cntNext   = 8'd1;
        end
      end
      WAIT: begin
        if (!access || DMem_Ready || lastCycle) begin
          stateNext = IDLE;
          cntNext   = 8'd0;
        end else begin
          cntNext = cnt + 8'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      Mem_Misalign    <= 1'b0;
      Mem_BusErr      <= 1'b0;
      MemWb_RegRd     <= 5'd0;
      MemWb_RegWrite  <= 1'b0;
      MemWb_MemToReg  <= 1'b0;
      MemWb_AluResult <= 32'd0;
      MemWb_ReadData  <= 32'd0;
    end else begin
      if (misaligned) Mem_Misalign <= 1'b1;
      if (abort)      Mem_BusErr   <= 1'b1;
      if (complete || (!access && !misaligned)) begin
        MemWb_RegRd     <= ExMem_RegRd;
        MemWb_RegWrite  <= ExMem_RegWrite;
        MemWb_MemToReg  <= ExMem_MemToReg;
        MemWb_AluResult <= ExMem_AluResult;
        if (complete && ExMem_MemRead) MemWb_ReadData <= DMem_RData;
      end else begin
        // Stall, misalign or abort: insert a bubble, keep data fields
        MemWb_RegRd    <= 5'd0;
        MemWb_RegWrite <= 1'b0;
        MemWb_MemToReg <= 1'b0;
      end
    end
  end

  assign Wb_RegWData = MemWb_MemToReg ? MemWb_ReadData : MemWb_AluResult;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage: bus and write-back monitors fed by directed stimulus
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] ExMem_AluResult, ExMem_AluB_Pc4;
  logic        ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg, ExMem_RegWrite;
  logic [4:0]  ExMem_RegRd;
  logic        DMem_Req, DMem_We, DMem_Ready;
  logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
  logic        Mem_Stall, Mem_Misalign, Mem_BusErr;
  logic [4:0]  MemWb_RegRd;
  logic        MemWb_RegWrite, MemWb_MemToReg;
  logic [31:0] MemWb_AluResult, MemWb_ReadData, Wb_RegWData;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busT;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbT;

  busT busQ[$];
  wbT  wbQ[$];
  int  nChecks = 0;
  int  nFails  = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstb(rstb),
    .ExMem_AluResult(ExMem_AluResult), .ExMem_AluB_Pc4(ExMem_AluB_Pc4),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemWrite(ExMem_MemWrite),
    .ExMem_MemToReg(ExMem_MemToReg), .ExMem_RegRd(ExMem_RegRd),
    .ExMem_RegWrite(ExMem_RegWrite),
    .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
    .DMem_WData(DMem_WData), .DMem_Ready(DMem_Ready), .DMem_RData(DMem_RData),
    .Mem_Stall(Mem_Stall), .Mem_Misalign(Mem_Misalign), .Mem_BusErr(Mem_BusErr),
    .MemWb_RegRd(MemWb_RegRd), .MemWb_RegWrite(MemWb_RegWrite),
    .MemWb_MemToReg(MemWb_MemToReg), .MemWb_AluResult(MemWb_AluResult),
    .MemWb_ReadData(MemWb_ReadData), .Wb_RegWData(Wb_RegWData)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus monitor: every Req cycle must match the head transfer; pop on completion or abort
  always @(negedge clk) begin
    if (rstb && DMem_Req) begin
      if (busQ.size() == 0) begin
        check("unexpected_req", 32'd1, 32'd0);
      end else begin
        check("bus_we", 32'(DMem_We), 32'(busQ[0].we));
        check("bus_addr", DMem_Addr, busQ[0].addr);
        if (busQ[0].we) check("bus_wdata", DMem_WData, busQ[0].wdata);
        if (DMem_Ready || !Mem_Stall) void'(busQ.pop_front());
      end
    end
  end

  // Write-back monitor: each valid MEM/WB cycle retires one expected register write
  always @(negedge clk) begin
    if (rstb && MemWb_RegWrite) begin
      if (wbQ.size() == 0) begin
        check("unexpected_wb", 32'(MemWb_RegRd), 32'd0);
      end else begin
        check("wb_rd", 32'(MemWb_RegRd), 32'(wbQ[0].rd));
        check("wb_data", Wb_RegWData, wbQ[0].data);
        void'(wbQ.pop_front());
      end
    end
  end

  task automatic setIn(input logic rd, input logic wr, input logic toReg, input logic regWr,
                       input logic [4:0] rdAddr, input logic [31:0] addr, input logic [31:0] data);
    ExMem_MemRead   = rd;
    ExMem_MemWrite  = wr;
    ExMem_MemToReg  = toReg;
    ExMem_RegWrite  = regWr;
    ExMem_RegRd     = rdAddr;
    ExMem_AluResult = addr;
    ExMem_AluB_Pc4  = data;
  endtask

  // Holds the current inputs; Ready rises in cycle index `waits` (negative = never)
  task automatic runAccess(input int waits, input int maxCycles, input logic [31:0] rdata,
                           output int reqCnt, output int stallCnt);
    reqCnt   = 0;
    stallCnt = 0;
    DMem_RData = rdata;
    for (int c = 0; c < maxCycles; c++) begin
      DMem_Ready = (c == waits);
      @(negedge clk);
      if (DMem_Req) reqCnt++;
      if (Mem_Stall) stallCnt++;
      @(posedge clk);
      #1;
      if (c == waits) break;
    end
    DMem_Ready = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req"}, 32'(DMem_Req), 32'd0);
    check({tag, "_stall"}, 32'(Mem_Stall), 32'd0);
    check({tag, "_memwb_rd"}, 32'(MemWb_RegRd), 32'd0);
    check({tag, "_memwb_we"}, 32'(MemWb_RegWrite), 32'd0);
    check({tag, "_memwb_alu"}, MemWb_AluResult, 32'd0);
    check({tag, "_memwb_rdata"}, MemWb_ReadData, 32'd0);
    check({tag, "_wbdata"}, Wb_RegWData, 32'd0);
    check({tag, "_flags"}, {30'd0, Mem_Misalign, Mem_BusErr}, 32'd0);
  endtask

  int req, stl;

  initial begin
    rstb = 1'b0;
    DMem_Ready = 1'b0;
    DMem_RData = 32'd0;
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h100, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait load
    busQ.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'd0});
    wbQ.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h100, 32'd0);
    runAccess(0, 1, 32'hDEADBEEF, req, stl);
    check("zw_req_cycles", 32'(req), 32'd1);
    check("zw_stall_cycles", 32'(stl), 32'd0);
    check("zw_memwb_we", 32'(MemWb_RegWrite), 32'd1);

    // Store with 3 wait states, back-to-back with the load
    busQ.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'h12345678});
    setIn(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h200, 32'h12345678);
    runAccess(3, 4, 32'hFFFFFFFF, req, stl);
    check("st_req_cycles", 32'(req), 32'd4);
    check("st_stall_cycles", 32'(stl), 32'd3);

    // ALU op with stray Ready while Req is low
    wbQ.push_back('{rd: 5'd3, data: 32'h55});
    setIn(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55, 32'd0);
    runAccess(0, 1, 32'hAAAAAAAA, req, stl);
    check("alu_req_cycles", 32'(req), 32'd0);
    check("alu_stall_cycles", 32'(stl), 32'd0);

    // Misaligned load, then aligned load with one wait state
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h102, 32'd0);
    runAccess(0, 1, 32'h11111111, req, stl);
    check("mis_req_cycles", 32'(req), 32'd0);
    check("mis_stall_cycles", 32'(stl), 32'd0);
    check("mis_flag", 32'(Mem_Misalign), 32'd1);
    check("mis_bubble", 32'(MemWb_RegWrite), 32'd0);
    busQ.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'd0});
    wbQ.push_back('{rd: 5'd8, data: 32'hCAFEF00D});
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h104, 32'd0);
    runAccess(1, 2, 32'hCAFEF00D, req, stl);
    check("al_req_cycles", 32'(req), 32'd2);
    check("al_stall_cycles", 32'(stl), 32'd1);

    // Ready in the final timeout cycle wins over abort
    busQ.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'd0});
    wbQ.push_back('{rd: 5'd9, data: 32'h0BADCAFE});
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h300, 32'd0);
    runAccess(TIMEOUT - 1, TIMEOUT, 32'h0BADCAFE, req, stl);
    check("late_req_cycles", 32'(req), 32'(TIMEOUT));
    check("late_stall_cycles", 32'(stl), 32'(TIMEOUT - 1));
    check("late_buserr", 32'(Mem_BusErr), 32'd0);

    // Pure timeout
    busQ.push_back('{we: 1'b0, addr: 32'h304, wdata: 32'd0});
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h304, 32'd0);
    runAccess(-1, TIMEOUT, 32'h22222222, req, stl);
    check("to_req_cycles", 32'(req), 32'(TIMEOUT));
    check("to_stall_cycles", 32'(stl), 32'(TIMEOUT - 1));
    check("to_buserr", 32'(Mem_BusErr), 32'd1);
    check("to_bubble_rd", 32'(MemWb_RegRd), 32'd0);
    check("to_bubble_we", 32'(MemWb_RegWrite), 32'd0);

    // Reset during the second wait cycle
    busQ.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'd0});
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h400, 32'd0);
    DMem_Ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    checkResetOutputs("midwait_rst");
    busQ.delete();
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;

    // After release the FSM must be IDLE: a one-wait load behaves normally
    busQ.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'd0});
    wbQ.push_back('{rd: 5'd12, data: 32'h5A5A5A5A});
    setIn(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h500, 32'd0);
    runAccess(1, 2, 32'h5A5A5A5A, req, stl);
    check("post_rst_req_cycles", 32'(req), 32'd2);
    check("post_rst_stall_cycles", 32'(stl), 32'd1);
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_drained", 32'(busQ.size()), 32'd0);
    check("wb_queue_drained", 32'(wbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
